// File: rtl/am_pkg.sv
// Shared definitions for the AM modem core: mode encodings, default widths,
// and the quarter-wave sine magnitude table (amplitude 127, 64 entries).
package am_pkg;

  localparam int unsigned AM_DW_DEF = 8;
  localparam int unsigned AM_PW_DEF = 16;
  localparam int unsigned AM_LW_DEF = 4;
  localparam int unsigned AM_LUT_IW = 8;

  typedef enum logic [1:0] {
    AM_DSB_LC     = 2'b00,
    AM_DSB_SC     = 2'b01,
    AM_BYPASS     = 2'b10,
    AM_DSB_LC_ALT = 2'b11
  } am_mode_e;

  // round(127*sin(2*pi*k/256)) for k = 0..63
  localparam logic [6:0] SINE_Q127 [64] = '{
    7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
    7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
    7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
    7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
    7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
    7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
    7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127
  };

endpackage

// File: rtl/am_sine_lut.sv
// Registered quarter-wave sine LUT.
// Ports: clk_in/rst (sync, active-high), idx (8-bit phase index),
//        carrier (signed DW-bit sample, one cycle after idx).
module am_sine_lut
  import am_pkg::*;
#(
  parameter int unsigned DW = AM_DW_DEF
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic [AM_LUT_IW-1:0]    idx,
  output logic signed [DW-1:0]    carrier
);

  localparam int unsigned AMP = (32'd1 << (DW - 1)) - 32'd1;

  logic                   mirror;
  logic                   neg;
  logic [5:0]             j;
  logic [5:0]             addr;
  logic [31:0]            mag;
  logic signed [DW-1:0]   carrier_c;

  // Fold the index into the first quadrant; the 90-degree peak is not stored.
  // The stored table is exact for amplitude 127 and rescaled for other widths.
  always_comb begin
    mirror    = idx[6];
    neg       = idx[7];
    j         = idx[5:0];
    addr      = mirror ? 6'(7'd64 - 7'(j)) : j;
    mag       = (32'(SINE_Q127[addr]) * 32'(AMP) + 32'd63) / 32'd127;
    if (mirror && (j == 6'd0)) begin
      mag = 32'(AMP);
    end
    carrier_c = neg ? DW'(-mag) : DW'(mag);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      carrier <= '0;
    end else begin
      carrier <= carrier_c;
    end
  end

endmodule

// File: rtl/am_modem_core.sv
// AM modulator with coherent product demodulator and moving-average filter.
// Ports: clk_in, rst (sync, active-high); cfg_we/fcw/dc_offset/mode config
//        load; msg_valid/msg/msg_ready message input; mod_valid/mod_out
//        modulated output (T+2); demod_valid/demod_out averaged output (T+4).
module am_modem_core
  import am_pkg::*;
#(
  parameter int unsigned DW = AM_DW_DEF,
  parameter int unsigned PW = AM_PW_DEF,
  parameter int unsigned LW = AM_LW_DEF
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [PW-1:0]           fcw,
  input  logic signed [DW-1:0]    dc_offset,
  input  logic [1:0]              mode,
  input  logic                    msg_valid,
  input  logic signed [DW-1:0]    msg,
  output logic                    msg_ready,
  output logic                    mod_valid,
  output logic signed [2*DW:0]    mod_out,
  output logic                    demod_valid,
  output logic signed [3*DW:0]    demod_out
);

  localparam int unsigned EW   = DW + 1;
  localparam int unsigned MW   = 2 * DW + 1;
  localparam int unsigned PRW  = 3 * DW + 1;
  localparam int unsigned SW   = PRW + LW;
  localparam int unsigned N    = 32'd1 << LW;
  localparam logic [LW:0] FULL = (LW + 1)'(N);

  logic                  accept;
  logic [PW-1:0]         fcw_q;
  logic signed [DW-1:0]  dc_q;
  am_mode_e              mode_q;
  logic [PW-1:0]         phase;

  logic signed [EW-1:0]  env_c;
  logic                  v1, v2, byp1, byp2;
  logic signed [EW-1:0]  env1, env2;
  logic [AM_LUT_IW-1:0]  idx1;
  logic signed [DW-1:0]  car2, car3;
  logic signed [MW-1:0]  mod_c;

  logic                  pv;
  logic signed [PRW-1:0] prod;
  logic signed [PRW-1:0] ma_buf [N];
  logic [LW-1:0]         wr_ptr;
  logic signed [SW-1:0]  sum, sum_next;
  logic [LW:0]           fill, fill_next;

  // Configuration wins over a simultaneous message sample.
  assign msg_ready = ~rst & ~cfg_we;
  assign accept    = msg_valid & msg_ready;

  // Configuration registers and phase accumulator.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      fcw_q  <= '0;
      dc_q   <= '0;
      mode_q <= AM_DSB_LC;
      phase  <= '0;
    end else if (cfg_we) begin
      fcw_q  <= fcw;
      dc_q   <= dc_offset;
      mode_q <= am_mode_e'(mode);
      phase  <= '0;
    end else if (accept) begin
      phase  <= phase + fcw_q;
    end
  end

  // Envelope; suppressed-carrier mode drops the offset.
  always_comb begin
    env_c = EW'(dc_q) + EW'(msg);
    if (mode_q == AM_DSB_SC) begin
      env_c = EW'(msg);
    end
  end

  am_sine_lut #(.DW(DW)) u_lut (
    .clk_in  (clk_in),
    .rst     (rst),
    .idx     (idx1),
    .carrier (car2)
  );

  assign mod_c = byp2 ? MW'(car2) : MW'(env2) * MW'(car2);

  // Modulator pipeline: capture (T), LUT read (T+1), multiply (T+2).
  always_ff @(posedge clk_in) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      mod_valid <= 1'b0;
      byp1      <= 1'b0;
      byp2      <= 1'b0;
      env1      <= '0;
      env2      <= '0;
      idx1      <= '0;
      car3      <= '0;
      mod_out   <= '0;
    end else if (cfg_we) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      mod_valid <= 1'b0;
    end else begin
      v1 <= accept;
      if (accept) begin
        env1 <= env_c;
        idx1 <= phase[PW-1 -: AM_LUT_IW];
        byp1 <= (mode_q == AM_BYPASS);
      end
      v2        <= v1;
      env2      <= env1;
      byp2      <= byp1;
      mod_valid <= v2;
      if (v2) begin
        mod_out <= mod_c;
        car3    <= car2;
      end
    end
  end

  // Coherent product with the same carrier sample (T+3).
  always_ff @(posedge clk_in) begin
    if (rst) begin
      pv   <= 1'b0;
      prod <= '0;
    end else if (cfg_we) begin
      pv   <= 1'b0;
    end else begin
      pv <= mod_valid;
      if (mod_valid) begin
        prod <= PRW'(mod_out) * PRW'(car3);
      end
    end
  end

  assign sum_next  = sum + SW'(prod) - SW'(ma_buf[wr_ptr]);
  assign fill_next = (fill == FULL) ? FULL : fill + (LW + 1)'(1);

  // Running-sum moving average over the last N products (T+4).
  always_ff @(posedge clk_in) begin
    if (rst || cfg_we) begin
      for (int unsigned i = 0; i < N; i++) begin
        ma_buf[i] <= '0;
      end
      wr_ptr      <= '0;
      sum         <= '0;
      fill        <= '0;
      demod_valid <= 1'b0;
      if (rst) begin
        demod_out <= '0;
      end
    end else begin
      demod_valid <= pv && (fill_next == FULL);
      if (pv) begin
        ma_buf[wr_ptr] <= prod;
        wr_ptr         <= wr_ptr + LW'(1);
        sum            <= sum_next;
        fill           <= fill_next;
        if (fill_next == FULL) begin
          demod_out <= PRW'(sum_next >>> LW);
        end
      end
    end
  end

endmodule

// File: tb/tb_am_modem_core.sv
// Scoreboard bench for am_modem_core: a floating-point reference model
// predicts every modulated/demodulated sample and its arrival cycle.
module tb_am_modem_core;

  localparam int DW = 8;
  localparam int PW = 16;
  localparam int LW = 4;
  localparam int N  = 16;

  logic                 clk_in = 1'b0;
  logic                 rst = 1'b1;
  logic                 cfg_we = 1'b0;
  logic [PW-1:0]        fcw = '0;
  logic signed [DW-1:0] dc_offset = '0;
  logic [1:0]           mode = '0;
  logic                 msg_valid = 1'b0;
  logic signed [DW-1:0] msg = '0;
  logic                 msg_ready;
  logic                 mod_valid;
  logic signed [2*DW:0] mod_out;
  logic                 demod_valid;
  logic signed [3*DW:0] demod_out;

  am_modem_core #(.DW(DW), .PW(PW), .LW(LW)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .fcw         (fcw),
    .dc_offset   (dc_offset),
    .mode        (mode),
    .msg_valid   (msg_valid),
    .msg         (msg),
    .msg_ready   (msg_ready),
    .mod_valid   (mod_valid),
    .mod_out     (mod_out),
    .demod_valid (demod_valid),
    .demod_out   (demod_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    longint val;
    int     cyc;
  } exp_t;

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  exp_t   mod_q[$];
  exp_t   dem_q[$];
  longint window[$];
  int     m_phase, m_fcw, m_dc, m_mode, m_cnt;
  longint last_mod = 0;
  longint last_dem = 0;
  int     mod_seen[$];
  int     dem_seen = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int sine_ref(input int k);
    real x;
    x = 127.0 * $sin(6.283185307179586 * real'(k) / 256.0);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  function automatic void model_accept(input int m);
    int     c, e, md;
    longint p, s;
    exp_t   x;
    c = sine_ref((m_phase >> 8) & 255);
    e = (m_mode == 1) ? m : m_dc + m;
    md = (m_mode == 2) ? c : e * c;
    x.val = md;
    x.cyc = cyc + 2;
    mod_q.push_back(x);
    p = longint'(md) * c;
    window.push_back(p);
    if (window.size() > N) void'(window.pop_front());
    m_cnt++;
    if (m_cnt >= N) begin
      s = 0;
      foreach (window[i]) s += window[i];
      x.val = s >>> LW;
      x.cyc = cyc + 4;
      dem_q.push_back(x);
    end
    m_phase = (m_phase + m_fcw) & 32'h0000_FFFF;
  endfunction

  // One clock edge: apply to the model whatever the DUT sees on this edge.
  task automatic tick();
    @(posedge clk_in);
    cyc++;
    if (rst) begin
      m_phase = 0; m_fcw = 0; m_dc = 0; m_mode = 0; m_cnt = 0;
      window.delete(); mod_q.delete(); dem_q.delete();
      last_mod = 0; last_dem = 0;
    end else if (cfg_we) begin
      m_fcw = int'(fcw); m_dc = int'(dc_offset); m_mode = int'(mode);
      m_phase = 0; m_cnt = 0;
      window.delete(); mod_q.delete(); dem_q.delete();
    end else if (msg_valid) begin
      model_accept(int'(msg));
    end
    #1;
  endtask

  task automatic drive(input bit v, input int m);
    msg_valid = v;
    msg = 8'(m);
    tick();
  endtask

  task automatic configure(input int f, input int d, input int md);
    cfg_we = 1'b1; fcw = 16'(f); dc_offset = 8'(d); mode = 2'(md);
    tick();
    cfg_we = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every valid, checks hold otherwise.
  always @(negedge clk_in) begin : mon
    exp_t e;
    check("msg_ready", longint'(msg_ready), longint'(!rst && !cfg_we));
    if (mod_valid) begin
      if (mod_q.size() == 0) begin
        check("mod_valid_unexpected", longint'(mod_valid), 0);
      end else begin
        e = mod_q.pop_front();
        check("mod_out", mod_out, e.val);
        check("mod_latency", cyc, e.cyc);
        last_mod = e.val;
        mod_seen.push_back(int'(mod_out));
      end
    end else begin
      check("mod_hold", mod_out, last_mod);
    end
    if (demod_valid) begin
      if (dem_q.size() == 0) begin
        check("demod_valid_unexpected", longint'(demod_valid), 0);
      end else begin
        e = dem_q.pop_front();
        check("demod_out", demod_out, e.val);
        check("demod_latency", cyc, e.cyc);
        last_dem = e.val;
        dem_seen++;
      end
    end else begin
      check("demod_hold", demod_out, last_dem);
    end
  end

  initial begin
    int exp4[4];
    exp4[0] = 0; exp4[1] = 8128; exp4[2] = 0; exp4[3] = -8128;

    // Reset held three cycles.
    repeat (3) tick();
    check("rst_mod_valid", longint'(mod_valid), 0);
    check("rst_demod_valid", longint'(demod_valid), 0);
    check("rst_mod_out", mod_out, 0);
    check("rst_demod_out", demod_out, 0);
    check("rst_msg_ready", longint'(msg_ready), 0);
    rst = 1'b0;
    tick();
    check("rel_msg_ready", longint'(msg_ready), 1);
    check("rel_mod_valid", longint'(mod_valid), 0);
    check("rel_demod_valid", longint'(demod_valid), 0);

    // Quarter-rate carrier, DSB-LC, zero message.
    configure(32'h4000, 64, 0);
    mod_seen.delete(); dem_seen = 0;
    repeat (20) drive(1'b1, 0);
    drive(1'b0, 0); repeat (7) drive(1'b0, 0);
    check("dir_mod_count", mod_seen.size(), 20);
    for (int i = 0; i < 4; i++) check("dir_mod_seq", mod_seen[i], exp4[i]);
    check("dir_demod_count", dem_seen, 5);
    check("dir_demod_value", demod_out, 516128);

    // Alternating valid: phase advances only on accepts.
    configure(32'h4000, 64, 0);
    mod_seen.delete();
    for (int i = 0; i < 16; i++) drive(i % 2 == 0, 0);
    repeat (6) drive(1'b0, 0);
    check("alt_mod_count", mod_seen.size(), 8);
    for (int i = 0; i < 8; i++) check("alt_mod_seq", mod_seen[i], exp4[i % 4]);

    // Reconfigure mid-stream with a sample offered in the same cycle.
    configure(32'h4000, 64, 0);
    repeat (20) drive(1'b1, $urandom_range(0, 255));
    cfg_we = 1'b1; fcw = 16'h4000; dc_offset = 8'd64; mode = 2'd0;
    msg_valid = 1'b1; msg = 8'd5;
    tick();
    cfg_we = 1'b0;
    dem_seen = 0;
    repeat (15) drive(1'b1, $urandom_range(0, 255));
    repeat (6) drive(1'b0, 0);
    check("cfg_no_early_demod", dem_seen, 0);
    drive(1'b1, 3);
    repeat (6) drive(1'b0, 0);
    check("cfg_first_demod", dem_seen, 1);

    // Carrier bypass ignores message and offset.
    configure(32'h4000, $urandom_range(0, 255), 2);
    mod_seen.delete();
    repeat (8) drive(1'b1, $urandom_range(0, 255));
    repeat (4) drive(1'b0, 0);
    check("byp_mod_count", mod_seen.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check("byp_mod_seq", mod_seen[i], (exp4[i % 4] == 0) ? 0 : exp4[i % 4] / 64);
    end

    // Randomized configurations, gaps, reconfigurations and resets.
    for (int r = 0; r < 8; r++) begin
      configure($urandom_range(0, 65535), $urandom_range(0, 255), $urandom_range(0, 3));
      for (int i = 0; i < 70; i++) begin
        if (r == 3 && i == 35) begin
          rst = 1'b1;
          drive(1'b1, $urandom_range(0, 255));
          drive(1'b0, 0);
          rst = 1'b0;
          configure($urandom_range(0, 65535), $urandom_range(0, 255), $urandom_range(0, 3));
        end else if ($urandom_range(0, 49) == 0) begin
          cfg_we = 1'b1; fcw = 16'($urandom_range(0, 65535));
          msg_valid = 1'b1;
          tick();
          cfg_we = 1'b0;
        end else begin
          drive($urandom_range(0, 3) != 0, $urandom_range(0, 255));
        end
      end
    end

    repeat (10) drive(1'b0, 0);
    check("mod_queue_drained", mod_q.size(), 0);
    check("demod_queue_drained", dem_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/am_modem_core.md
AM_MODEM_CORE -- requirements
Module: am_modem_core

Interface
REQ-001 Parameter DW, default 8: message/carrier sample width, signed two's complement.
REQ-002 Parameter PW, default 16: phase accumulator width.
REQ-003 Parameter LW, default 4: log2 of demodulator moving-average depth (window N = 2^LW).
REQ-004 clk_in  in  1  single clock; all logic rising-edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 cfg_we  in  1  one-cycle configuration load strobe.
REQ-007 fcw  in  PW  carrier frequency word, sampled on cfg_we.
REQ-008 dc_offset  in  DW  signed carrier-level offset, sampled on cfg_we.
REQ-009 mode  in  2  00 DSB-LC AM, 01 DSB-SC (offset forced 0), 10 carrier bypass, 11 treated as 00; sampled on cfg_we.
REQ-010 msg_valid / msg  in  1 / DW  message sample and its valid.
REQ-011 msg_ready  out  1  sample accepted when msg_valid & msg_ready.
REQ-012 mod_valid / mod_out  out  1 / 2*DW+1  modulated sample, signed.
REQ-013 demod_valid / demod_out  out  1 / 3*DW+1  demodulated sample, signed.

Function
REQ-014 msg_ready = ~rst & ~cfg_we; cfg_we with msg_valid in same cycle: configuration wins, sample not accepted.
REQ-015 Phase accumulator advances by fcw (mod 2^PW, wrap silent) only on accepted samples; accepted sample uses pre-increment phase.
REQ-016 Carrier = sine LUT indexed by phase[PW-1 -: 8], value round((2^(DW-1)-1)*sin(2*pi*k/256)), quarter-wave symmetry, 64 stored entries.
REQ-017 Envelope e = dc_offset + msg (DW+1 bits, no overflow); mode 01: e = msg.
REQ-018 mod_out = e * carrier (mode 00/01) or carrier sign-extended (mode 10), full width, no truncation.
REQ-019 Sample accepted at edge T: mod_valid/mod_out update at edge T+2; mod_valid is one pulse per accepted sample; gaps in msg_valid reproduced as gaps in mod_valid.
REQ-020 Demod product p = mod_out * aligned carrier (same carrier sample, 3*DW+1 bits), registered at T+3.
REQ-021 Moving average: circular buffer of N products, running sum S += p_new - p_oldest (3*DW+1+LW bits), updated at T+4; demod_out = S >>> LW (arithmetic).
REQ-022 Fill counter counts products since last clear, saturating at N; demod_valid pulses with each new average only once counter = N (first valid on Nth product).
REQ-023 cfg_we: register fcw/dc_offset/mode, clear phase accumulator, all pipeline valids, buffer contents, S and fill counter on that edge; in-flight samples discarded.
REQ-024 Outputs held (not zeroed) between valid pulses.

Reset
REQ-025 On rst: phase=0, fcw=0, dc_offset=0, mode=00, buffer/S/fill counter=0, all valids=0, mod_out=0, demod_out=0, msg_ready=0.
REQ-026 rst mid-stream discards all in-flight samples; no valid pulse on the edge after rst deasserts.

Structure
REQ-027 Shared package am_pkg: mode encodings (AM_DSB_LC, AM_DSB_SC, AM_BYPASS), default DW/PW/LW, LUT index width constant 8.
REQ-028 One sub-module am_sine_lut (registered quarter-wave LUT, parameter DW); moving average inline.

Verification (DW=8, PW=16, LW=4)
REQ-029 rst held 3 cycles -> all outputs 0, msg_ready 0; cycle after release msg_ready 1, no valids.
REQ-030 cfg fcw=0x4000, dc_offset=64, mode 00, msg=0 streamed -> carrier 0,127,0,-127; mod_out 0,8128,0,-8128 two cycles after each accept.
REQ-031 Same stream 16 samples -> demod_valid first on 16th product, demod_out = 8*1032256/16 = 516128, steady thereafter.
REQ-032 msg_valid alternating 1/0 -> phase advances only on accepts, mod_valid alternating 1/0 delayed 2 cycles, mod_out sequence unchanged.
REQ-033 cfg_we asserted with msg_valid=1 mid-stream -> msg_ready 0 that cycle, pending mod/demod valids dropped, demod_valid low until 16 new products.
REQ-034 mode 10, fcw=0x4000 -> mod_out 0,127,0,-127 regardless of msg/dc_offset.
